pc_control: RTL

- Program-counter owner for the MIPS fetch stage: holds the PC register and computes PC+4.
- Produces the next-PC select, plus the write/flush strobes consumed by the IF stage and the IF/ID latch.
- Gates PC advance by debug run mode (continuous or single-step), load-use stall, branch/jump redirect and halt detection.
- Sits between the debug unit and the hazard unit on one side, and instruction memory and the IF/ID register on the other.

---
 rtl/pc_ctrl_pkg.sv | 16 +
 rtl/pc_control_adder.sv | 12 +
 rtl/pc_control.sv | 108 ++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: FSM encoding,
// debug run-mode constants and the default sequential increment.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } pc_state_e;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  localparam int unsigned PC_INC_DEFAULT = 32'd4;

endpackage : pc_ctrl_pkg

// File: rtl/pc_control_adder.sv
// Fixed-increment PC adder; the sum wraps modulo 2^len with no carry out.
module pc_adder #(
  parameter int unsigned     len    = 32,
  parameter logic [len-1:0]  PC_INC = len'(4)
) (
  input  logic [len-1:0] i_pc,
  output logic [len-1:0] o_sum
);

  assign o_sum = i_pc + PC_INC;

endmodule : pc_adder

// File: rtl/pc_control.sv
// Program-counter owner for the MIPS fetch stage. Holds the PC, gates its
// advance by debug run mode, hazard stall, branch/jump redirect and halt,
// and drives the next-PC select and IF/ID write/flush strobes.
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned    len      = 32,
  parameter logic [len-1:0] RESET_PC = '0,
  parameter logic [len-1:0] PC_INC   = len'(PC_INC_DEFAULT)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_mode,
  input  logic           i_enable,
  input  logic           i_step,
  input  logic           i_stall,
  input  logic           i_redirect,
  input  logic [len-1:0] i_redirect_addr,
  input  logic           i_halt,
  output logic [len-1:0] o_pc,
  output logic [len-1:0] o_pc_plus,
  output logic           o_pc_sel,
  output logic           o_pc_write,
  output logic           o_flush,
  output logic           o_halted
);

  pc_state_e      state_q, state_d;
  logic [len-1:0] pc_q, pc_d;
  logic [len-1:0] pc_plus_s;
  logic           act_s;
  logic           pc_sel_s, pc_write_s, flush_s;

  pc_adder #(
    .len    (len),
    .PC_INC (PC_INC)
  ) u_pc_adder (
    .i_pc  (pc_q),
    .o_sum (pc_plus_s)
  );

  // A cycle counts as active when the debug unit lets the core run in the selected mode.
  always_comb begin
    act_s = (i_mode == MODE_CONT) ? i_enable : i_step;
  end

  // Next-state, next-PC and same-cycle strobe decode; redirect outranks stall and halt
  // because the stalled or halting instruction is on the wrong path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_sel_s   = 1'b0;
    pc_write_s = 1'b0;
    flush_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (act_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!act_s) begin
          pc_d = pc_q;
        end else if (i_redirect) begin
          pc_sel_s   = 1'b1;
          pc_write_s = 1'b1;
          flush_s    = 1'b1;
          pc_d       = i_redirect_addr;
        end else if (i_stall) begin
          pc_d = pc_q;
        end else if (i_halt) begin
          state_d = ST_HALTED;
        end else begin
          pc_write_s = 1'b1;
          pc_d       = pc_plus_s;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // PC and FSM state registers; reset clears both immediately, dropping any pending redirect.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_plus  = pc_plus_s;
  assign o_pc_sel   = pc_sel_s;
  assign o_pc_write = pc_write_s;
  assign o_flush    = flush_s;
  assign o_halted   = (state_q == ST_HALTED);

endmodule : pc_control
